// File: rtl/mips_alu.sv
// Registered 32-bit MIPS-style ALU for the execute stage: decodes opcode/funct,
// produces the result and the branch-taken flag one cycle after the inputs.
module mips_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  input  logic [4:0]  shamt,
  input  logic [5:0]  ALU_control,
  input  logic [15:0] immediate,
  output logic [31:0] ALU_result,
  output logic        sig_branch
);

  logic [31:0] imm_se;
  logic [31:0] imm_ze;
  logic [31:0] result_d;
  logic        branch_d;
  logic [4:0]  var_shamt;

  assign imm_se    = {{16{immediate[15]}}, immediate};
  assign imm_ze    = {16'b0, immediate};
  assign var_shamt = rs_content[4:0];

  always_comb begin
    result_d = 32'b0;
    branch_d = 1'b0;
    unique case (opcode)
      6'b000000: begin
        unique case (ALU_control)
          6'b100000, 6'b100001: result_d = rs_content + rt_content;
          6'b100010, 6'b100011: result_d = rs_content - rt_content;
          6'b100100: result_d = rs_content & rt_content;
          6'b100101: result_d = rs_content | rt_content;
          6'b100110: result_d = rs_content ^ rt_content;
          6'b100111: result_d = ~(rs_content | rt_content);
          6'b101010: result_d = {31'b0, $signed(rs_content) < $signed(rt_content)};
          6'b101011: result_d = {31'b0, rs_content < rt_content};
          6'b000000: result_d = rt_content << shamt;
          6'b000010: result_d = rt_content >> shamt;
          6'b000011: result_d = $unsigned($signed(rt_content) >>> shamt);
          6'b000100: result_d = rt_content << var_shamt;
          6'b000110: result_d = rt_content >> var_shamt;
          6'b000111: result_d = $unsigned($signed(rt_content) >>> var_shamt);
          default:   result_d = 32'b0;
        endcase
      end
      6'b001000, 6'b001001: result_d = rs_content + imm_se;
      6'b001100: result_d = rs_content & imm_ze;
      6'b001101: result_d = rs_content | imm_ze;
      6'b001110: result_d = rs_content ^ imm_ze;
      6'b001010: result_d = {31'b0, $signed(rs_content) < $signed(imm_se)};
      // SLTIU still sign-extends the immediate, then compares unsigned.
      6'b001011: result_d = {31'b0, rs_content < imm_se};
      6'b001111: result_d = {immediate, 16'b0};
      6'b100011, 6'b101011: result_d = rs_content + imm_se;
      6'b000100: begin
        result_d = rs_content - rt_content;
        branch_d = (rs_content == rt_content);
      end
      6'b000101: begin
        result_d = rs_content - rt_content;
        branch_d = (rs_content != rt_content);
      end
      default: begin
        result_d = 32'b0;
        branch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_result <= 32'b0;
      sig_branch <= 1'b0;
    end else begin
      ALU_result <= result_d;
      sig_branch <= branch_d;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed cases plus randomized ops checked
// against a behavioural reference model.
module tb_mips_alu;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [31:0] rs_content;
  logic [31:0] rt_content;
  logic [4:0]  shamt;
  logic [5:0]  ALU_control;
  logic [15:0] immediate;
  logic [31:0] ALU_result;
  logic        sig_branch;

  int tests_run;
  int tests_failed;

  mips_alu dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .rs_content (rs_content),
    .rt_content (rt_content),
    .shamt      (shamt),
    .ALU_control(ALU_control),
    .immediate  (immediate),
    .ALU_result (ALU_result),
    .sig_branch (sig_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {branch, result} computed straight from the instruction semantics.
  function automatic logic [32:0] model(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [4:0] sh, input logic [15:0] imm);
    int signed   srs, srt, sse;
    logic [31:0] se, ze, r;
    logic        b;
    srs = rs; srt = rt;
    se  = {{16{imm[15]}}, imm};
    ze  = {16'h0, imm};
    sse = se;
    r = 0; b = 0;
    if (op == 6'd0) begin
      case (fn)
        6'd32, 6'd33: r = rs + rt;
        6'd34, 6'd35: r = rs - rt;
        6'd36: r = rs & rt;
        6'd37: r = rs | rt;
        6'd38: r = rs ^ rt;
        6'd39: r = ~(rs | rt);
        6'd42: r = (srs < srt) ? 32'd1 : 32'd0;
        6'd43: r = (rs < rt) ? 32'd1 : 32'd0;
        6'd0:  r = rt << sh;
        6'd2:  r = rt >> sh;
        6'd3:  r = srt >>> sh;
        6'd4:  r = rt << (rs % 32);
        6'd6:  r = rt >> (rs % 32);
        6'd7:  r = srt >>> (rs % 32);
        default: r = 0;
      endcase
    end else begin
      case (op)
        6'd8, 6'd9, 6'd35, 6'd43: r = rs + se;
        6'd12: r = rs & ze;
        6'd13: r = rs | ze;
        6'd14: r = rs ^ ze;
        6'd10: r = (srs < sse) ? 32'd1 : 32'd0;
        6'd11: r = (rs < se) ? 32'd1 : 32'd0;
        6'd15: r = imm * 32'd65536;
        6'd4:  begin r = rs - rt; b = (rs == rt); end
        6'd5:  begin r = rs - rt; b = (rs != rt); end
        default: r = 0;
      endcase
    end
    return {b, r};
  endfunction

  task automatic run_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] sh, input logic [15:0] imm);
    logic [32:0] exp;
    opcode = op; ALU_control = fn; rs_content = rs; rt_content = rt;
    shamt = sh; immediate = imm;
    exp = model(op, fn, rs, rt, sh, imm);
    @(posedge clk);
    #1;
    check({tag, ".res"}, ALU_result, exp[31:0]);
    check({tag, ".br"}, {31'b0, sig_branch}, {31'b0, exp[32]});
  endtask

  task automatic run_exact(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input logic [4:0] sh, input logic [15:0] imm,
                           input logic [31:0] exp_r, input logic exp_b);
    opcode = op; ALU_control = fn; rs_content = rs; rt_content = rt;
    shamt = sh; immediate = imm;
    @(posedge clk);
    #1;
    check({tag, ".res"}, ALU_result, exp_r);
    check({tag, ".br"}, {31'b0, sig_branch}, {31'b0, exp_b});
  endtask

  logic [5:0] op_list [13] = '{6'd0, 6'd8, 6'd9, 6'd12, 6'd13, 6'd14, 6'd10, 6'd11,
                               6'd15, 6'd35, 6'd43, 6'd4, 6'd5};
  logic [5:0] fn_list [16] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
                               6'd42, 6'd43, 6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};

  initial begin
    logic [5:0]  rop, rfn;
    logic [31:0] rrs, rrt;
    tests_run = 0; tests_failed = 0;
    rst = 1'b1; opcode = 0; ALU_control = 0; rs_content = 0; rt_content = 0;
    shamt = 0; immediate = 0;
    @(posedge clk); @(posedge clk); #1;
    check("reset.res", ALU_result, 32'h0);
    check("reset.br", {31'b0, sig_branch}, 32'h0);
    rst = 1'b0;

    // Hand-computed expectations.
    run_exact("add1", 6'd0, 6'd32, 32'd15, 32'd12, 5'd0, 16'd0, 32'd27, 1'b0);
    run_exact("add2", 6'd0, 6'd32, 32'd23, 32'd2, 5'd0, 16'd0, 32'd25, 1'b0);
    run_exact("add3", 6'd0, 6'd32, 32'd1, 32'd35, 5'd0, 16'd0, 32'd36, 1'b0);
    run_exact("addwrap", 6'd0, 6'd32, 32'hFFFFFFFF, 32'd1, 5'd0, 16'd0, 32'h0, 1'b0);
    run_exact("sub", 6'd0, 6'd34, 32'd1, 32'd35, 5'd0, 16'd0, 32'hFFFFFFDE, 1'b0);
    run_exact("slt", 6'd0, 6'd42, 32'hFFFFFFFF, 32'd1, 5'd0, 16'd0, 32'd1, 1'b0);
    run_exact("sltu", 6'd0, 6'd43, 32'hFFFFFFFF, 32'd1, 5'd0, 16'd0, 32'd0, 1'b0);
    run_exact("sra", 6'd0, 6'd3, 32'd0, 32'h80000000, 5'd4, 16'd0, 32'hF8000000, 1'b0);
    run_exact("sll0", 6'd0, 6'd0, 32'd0, 32'hDEADBEEF, 5'd0, 16'd0, 32'hDEADBEEF, 1'b0);
    run_exact("addi", 6'd8, 6'd0, 32'd10, 32'd0, 5'd0, 16'hFFFF, 32'd9, 1'b0);
    run_exact("ori", 6'd13, 6'd0, 32'd0, 32'd0, 5'd0, 16'h8000, 32'h00008000, 1'b0);
    run_exact("lui", 6'd15, 6'd0, 32'd0, 32'd0, 5'd0, 16'h1234, 32'h12340000, 1'b0);
    run_exact("beq", 6'd4, 6'd0, 32'd7, 32'd7, 5'd0, 16'd0, 32'd0, 1'b1);
    run_exact("bne_eq", 6'd5, 6'd0, 32'd7, 32'd7, 5'd0, 16'd0, 32'd0, 1'b0);
    run_exact("bne_ne", 6'd5, 6'd0, 32'd7, 32'd8, 5'd0, 16'd0, 32'hFFFFFFFF, 1'b1);
    run_exact("add_after_br", 6'd0, 6'd32, 32'd1, 32'd2, 5'd0, 16'd0, 32'd3, 1'b0);
    run_exact("bad_op", 6'd63, 6'd32, 32'd5, 32'd5, 5'd0, 16'd0, 32'd0, 1'b0);
    run_exact("bad_fn", 6'd0, 6'd63, 32'd5, 32'd5, 5'd0, 16'd0, 32'd0, 1'b0);

    // Reset in the middle of back-to-back ADDs.
    run_exact("pre_rst", 6'd0, 6'd32, 32'd100, 32'd1, 5'd0, 16'd0, 32'd101, 1'b0);
    rst = 1'b1;
    run_exact("in_rst", 6'd0, 6'd32, 32'd200, 32'd2, 5'd0, 16'd0, 32'd0, 1'b0);
    rst = 1'b0;
    run_exact("post_rst", 6'd0, 6'd32, 32'd300, 32'd3, 5'd0, 16'd0, 32'd303, 1'b0);

    for (int i = 0; i < 400; i++) begin
      rop = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                        : op_list[$urandom_range(0, 12)];
      rfn = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                        : fn_list[$urandom_range(0, 15)];
      rrs = $urandom;
      rrt = ($urandom_range(0, 3) == 0) ? rrs : $urandom;
      run_op("rand", rop, rfn, rrs, rrt, 5'($urandom_range(0, 31)), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
